game15_turn_controller: RTL and testbench

//  Sequences one game of "Fifteen" (magic-square tic-tac-toe) between a human and a strategy datapath.

---
 rtl/game15_turn_controller_if.sv | 34 +++
 rtl/game15_turn_controller.sv | 204 ++++++++++++++++++++
 tb/tb_game15_turn_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game15_turn_controller_if.sv
// Board/strategy-side bus of the Fifteen turn controller.
// master : the environment (board I/O buttons and strategy unit) driving the controller
// slave  : the controller itself
// Signals:
//   newGame_L, enter_L, hMove     board inputs (active-low restart, active-low commit, human number)
//   strat_req/strat_valid/move    request/valid handshake with the strategy unit
//   hSet, cSet                    ownership sets, bit i-1 => number i
//   cMove                         last computer move (0 = none)
//   illegal, win, lose, draw      status flags
interface game15_turn_controller_if;
   logic       newGame_L;
   logic       enter_L;
   logic [3:0] hMove;
   logic       strat_req;
   logic       strat_valid;
   logic [3:0] strat_move;
   logic [8:0] hSet;
   logic [8:0] cSet;
   logic [3:0] cMove;
   logic       illegal;
   logic       win;
   logic       lose;
   logic       draw;

   modport master (
      output newGame_L, enter_L, hMove, strat_valid, strat_move,
      input  strat_req, hSet, cSet, cMove, illegal, win, lose, draw
   );

   modport slave (
      input  newGame_L, enter_L, hMove, strat_valid, strat_move,
      output strat_req, hSet, cSet, cMove, illegal, win, lose, draw
   );
endinterface

// File: rtl/game15_turn_controller.sv
// Turn sequencer for one game of "Fifteen" (magic-square tic-tac-toe), computer vs human.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    slave side of game15_turn_controller_if (board inputs, strategy handshake,
//          ownership sets and result flags)
// The computer opens with FIRST_MOVE without asking the strategy unit. Each later computer
// move is requested with strat_req; an illegal proposal or STRAT_TIMEOUT cycles of silence
// falls back to the lowest free number.
module game15_turn_controller #(
   parameter logic [3:0]  FIRST_MOVE    = 4'd5,
   parameter int unsigned STRAT_TIMEOUT = 16
) (
   input logic                     clock,
   input logic                     reset,
   game15_turn_controller_if.slave bus
);

   localparam int unsigned CntW = (STRAT_TIMEOUT > 1) ? $clog2(STRAT_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(STRAT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StCFirst,
      StHWait,
      StHHold,
      StHIll,
      StCReq,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [8:0]      h_set_q, h_set_d;
   logic [8:0]      c_set_q, c_set_d;
   logic [3:0]      c_move_q, c_move_d;
   logic            illegal_q, illegal_d;
   logic            win_q, win_d;
   logic            lose_q, lose_d;
   logic            draw_q, draw_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [8:0]      taken;
   logic            commit;
   logic [3:0]      c_pick;
   logic [8:0]      c_set_new;

   // Magic square rows/cols/diagonals: every triple summing to 15.
   function automatic logic has_triple(input logic [8:0] s);
      has_triple = (s[1] & s[6] & s[5]) |  // 2 7 6
                   (s[8] & s[4] & s[0]) |  // 9 5 1
                   (s[3] & s[2] & s[7]) |  // 4 3 8
                   (s[1] & s[8] & s[3]) |  // 2 9 4
                   (s[6] & s[4] & s[2]) |  // 7 5 3
                   (s[5] & s[0] & s[7]) |  // 6 1 8
                   (s[1] & s[4] & s[7]) |  // 2 5 8
                   (s[3] & s[4] & s[5]);   // 4 5 6
   endfunction

   function automatic logic [8:0] num_mask(input logic [3:0] m);
      num_mask = 9'd0;
      if (m >= 4'd1 && m <= 4'd9) begin
         num_mask[m - 4'd1] = 1'b1;
      end
   endfunction

   function automatic logic is_legal(input logic [3:0] m, input logic [8:0] used);
      is_legal = (num_mask(m) != 9'd0) && ((num_mask(m) & used) == 9'd0);
   endfunction

   function automatic logic [3:0] lowest_free(input logic [8:0] used);
      lowest_free = 4'd0;
      for (int i = 8; i >= 0; i--) begin
         if (!used[i]) begin
            lowest_free = 4'(i + 1);
         end
      end
   endfunction

   assign taken = h_set_q | c_set_q;

   always_comb begin
      state_d   = state_q;
      h_set_d   = h_set_q;
      c_set_d   = c_set_q;
      c_move_d  = c_move_q;
      illegal_d = illegal_q;
      win_d     = win_q;
      lose_d    = lose_q;
      draw_d    = draw_q;
      cnt_d     = cnt_q;
      commit    = 1'b0;
      c_pick    = 4'd0;
      c_set_new = c_set_q;

      unique case (state_q)
         StCFirst: begin
            c_set_d  = c_set_q | num_mask(FIRST_MOVE);
            c_move_d = FIRST_MOVE;
            state_d  = StHWait;
         end

         StHWait: begin
            if (!bus.enter_L) begin
               if (is_legal(bus.hMove, taken)) begin
                  h_set_d   = h_set_q | num_mask(bus.hMove);
                  illegal_d = 1'b0;
                  state_d   = StHHold;
               end else begin
                  illegal_d = 1'b1;
                  state_d   = StHIll;
               end
            end
         end

         // hSet already holds the new move here, so the triple test sees the updated set.
         StHHold: begin
            if (bus.enter_L) begin
               if (has_triple(h_set_q)) begin
                  lose_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  cnt_d   = '0;
                  state_d = StCReq;
               end
            end
         end

         StHIll: begin
            if (bus.enter_L) begin
               state_d = StHWait;
            end
         end

         StCReq: begin
            if (bus.strat_valid) begin
               commit = 1'b1;
               c_pick = is_legal(bus.strat_move, taken) ? bus.strat_move : lowest_free(taken);
            end else if (cnt_q == CntLast) begin
               commit = 1'b1;
               c_pick = lowest_free(taken);
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end

            if (commit) begin
               c_set_new = c_set_q | num_mask(c_pick);
               c_set_d   = c_set_new;
               c_move_d  = c_pick;
               if (has_triple(c_set_new)) begin
                  win_d   = 1'b1;
                  state_d = StDone;
               end else if (&(c_set_new | h_set_q)) begin
                  draw_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StHWait;
               end
            end
         end

         StDone: begin
            // Terminal: only a restart leaves.
         end

         default: begin
            state_d = StCFirst;
         end
      endcase
   end

   // Restart via newGame_L behaves exactly like reset, including mid-handshake.
   always_ff @(posedge clock) begin
      if (reset || !bus.newGame_L) begin
         state_q   <= StCFirst;
         h_set_q   <= 9'd0;
         c_set_q   <= 9'd0;
         c_move_q  <= 4'd0;
         illegal_q <= 1'b0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
         draw_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         h_set_q   <= h_set_d;
         c_set_q   <= c_set_d;
         c_move_q  <= c_move_d;
         illegal_q <= illegal_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
         draw_q    <= draw_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.strat_req = (state_q == StCReq);
   assign bus.hSet      = h_set_q;
   assign bus.cSet      = c_set_q;
   assign bus.cMove     = c_move_q;
   assign bus.illegal   = illegal_q;
   assign bus.win       = win_q;
   assign bus.lose      = lose_q;
   assign bus.draw      = draw_q;

endmodule

// File: tb/tb_game15_turn_controller.sv
// Directed self-checking bench for game15_turn_controller.
module tb_game15_turn_controller;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   game15_turn_controller_if bus_if ();

   game15_turn_controller #(
      .FIRST_MOVE   (4'd5),
      .STRAT_TIMEOUT(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus_if.slave)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [3:0] m);
      bus_if.hMove   = m;
      bus_if.enter_L = 1'b0;
      tick();
   endtask

   task automatic release_btn;
      bus_if.enter_L = 1'b1;
      tick();
   endtask

   task automatic give(input logic [3:0] m);
      bus_if.strat_valid = 1'b1;
      bus_if.strat_move  = m;
      tick();
      bus_if.strat_valid = 1'b0;
      bus_if.strat_move  = 4'd0;
   endtask

   // Leaves the DUT in H_WAIT after the opening move.
   task automatic restart;
      bus_if.newGame_L = 1'b0;
      tick();
      bus_if.newGame_L = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      reset              = 1'b1;
      bus_if.newGame_L   = 1'b1;
      bus_if.enter_L     = 1'b1;
      bus_if.hMove       = 4'd0;
      bus_if.strat_valid = 1'b0;
      bus_if.strat_move  = 4'd0;
      tick();
      tick();
      checks++;
      if ({bus_if.hSet, bus_if.cSet, bus_if.cMove} !== 22'd0) begin
         $display("FAIL reset_sets got h=%b c=%b m=%0d want 0", bus_if.hSet, bus_if.cSet,
                  bus_if.cMove);
         errors++;
      end
      checks++;
      if ({bus_if.illegal, bus_if.win, bus_if.lose, bus_if.draw, bus_if.strat_req} !== 5'd0) begin
         $display("FAIL reset_flags got %b want 00000", {bus_if.illegal, bus_if.win, bus_if.lose,
                  bus_if.draw, bus_if.strat_req});
         errors++;
      end
      reset = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (bus_if.cSet !== 9'b000010000 || bus_if.cMove !== 4'd5) begin
         $display("FAIL first_move got c=%b m=%0d want 000010000 5", bus_if.cSet, bus_if.cMove);
         errors++;
      end
      checks++;
      if (bus_if.strat_req !== 1'b0 || bus_if.hSet !== 9'd0) begin
         $display("FAIL first_idle got req=%b h=%b want 0 0", bus_if.strat_req, bus_if.hSet);
         errors++;
      end
   endtask

   task automatic test_human_and_strat;
      press(4'd6);
      checks++;
      if (bus_if.hSet !== 9'b000100000 || bus_if.strat_req !== 1'b0) begin
         $display("FAIL h_commit got h=%b req=%b want 000100000 0", bus_if.hSet, bus_if.strat_req);
         errors++;
      end
      bus_if.hMove = 4'd3;  // changed while held: must be ignored
      tick();
      checks++;
      if (bus_if.hSet !== 9'b000100000) begin
         $display("FAIL h_hold_ignore got h=%b want 000100000", bus_if.hSet);
         errors++;
      end
      release_btn();
      checks++;
      if (bus_if.strat_req !== 1'b1) begin
         $display("FAIL req_after_release got %b want 1", bus_if.strat_req);
         errors++;
      end
      give(4'd1);
      checks++;
      if (bus_if.cSet !== 9'b000010001 || bus_if.cMove !== 4'd1 || bus_if.strat_req !== 1'b0) begin
         $display("FAIL strat_commit got c=%b m=%0d req=%b want 000010001 1 0", bus_if.cSet,
                  bus_if.cMove, bus_if.strat_req);
         errors++;
      end
   endtask

   task automatic test_illegal;
      press(4'd5);
      checks++;
      if (bus_if.illegal !== 1'b1 || bus_if.hSet !== 9'b000100000) begin
         $display("FAIL illegal_set got ill=%b h=%b want 1 000100000", bus_if.illegal,
                  bus_if.hSet);
         errors++;
      end
      release_btn();
      checks++;
      if (bus_if.strat_req !== 1'b0 || bus_if.illegal !== 1'b1) begin
         $display("FAIL illegal_release got req=%b ill=%b want 0 1", bus_if.strat_req,
                  bus_if.illegal);
         errors++;
      end
      press(4'd9);
      checks++;
      if (bus_if.illegal !== 1'b0 || bus_if.hSet !== 9'b100100000) begin
         $display("FAIL legal_after got ill=%b h=%b want 0 100100000", bus_if.illegal,
                  bus_if.hSet);
         errors++;
      end
      release_btn();
      give(4'd6);  // owned by human: fallback to lowest free, which is 2
      checks++;
      if (bus_if.cMove !== 4'd2 || bus_if.cSet !== 9'b000010011 || bus_if.win !== 1'b0) begin
         $display("FAIL strat_fallback got m=%0d c=%b win=%b want 2 000010011 0", bus_if.cMove,
                  bus_if.cSet, bus_if.win);
         errors++;
      end
   endtask

   task automatic test_timeout;
      int n;
      bus_if.newGame_L = 1'b0;
      tick();
      checks++;
      if ({bus_if.hSet, bus_if.cSet, bus_if.cMove, bus_if.illegal} !== 23'd0) begin
         $display("FAIL newgame_clear got h=%b c=%b m=%0d ill=%b want 0", bus_if.hSet,
                  bus_if.cSet, bus_if.cMove, bus_if.illegal);
         errors++;
      end
      bus_if.newGame_L = 1'b1;
      tick();
      press(4'd6);
      release_btn();
      n = 0;
      while (bus_if.strat_req === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 16) begin
         $display("FAIL timeout_cycles got %0d want 16", n);
         errors++;
      end
      checks++;
      if (bus_if.cMove !== 4'd1 || bus_if.cSet !== 9'b000010001) begin
         $display("FAIL timeout_move got m=%0d c=%b want 1 000010001", bus_if.cMove, bus_if.cSet);
         errors++;
      end
   endtask

   task automatic test_win;
      press(4'd2);
      release_btn();
      give(4'd9);
      tick();
      checks++;
      if (bus_if.cSet !== 9'b100010001 || bus_if.cMove !== 4'd9) begin
         $display("FAIL win_commit got c=%b m=%0d want 100010001 9", bus_if.cSet, bus_if.cMove);
         errors++;
      end
      checks++;
      if ({bus_if.win, bus_if.lose, bus_if.draw} !== 3'b100) begin
         $display("FAIL win_flags got %b want 100", {bus_if.win, bus_if.lose, bus_if.draw});
         errors++;
      end
      press(4'd3);
      release_btn();
      bus_if.strat_valid = 1'b1;
      bus_if.strat_move  = 4'd4;
      tick();
      bus_if.strat_valid = 1'b0;
      checks++;
      if (bus_if.hSet !== 9'b000100010 || bus_if.cSet !== 9'b100010001 ||
          bus_if.strat_req !== 1'b0 || bus_if.win !== 1'b1) begin
         $display("FAIL done_hold got h=%b c=%b req=%b win=%b want 000100010 100010001 0 1",
                  bus_if.hSet, bus_if.cSet, bus_if.strat_req, bus_if.win);
         errors++;
      end
   endtask

   task automatic test_lose;
      restart();
      press(4'd2);
      release_btn();
      give(4'd1);
      press(4'd7);
      release_btn();
      give(4'd3);
      press(4'd6);
      release_btn();
      tick();
      checks++;
      if (bus_if.hSet !== 9'b001100010 || bus_if.cSet !== 9'b000010101) begin
         $display("FAIL lose_sets got h=%b c=%b want 001100010 000010101", bus_if.hSet,
                  bus_if.cSet);
         errors++;
      end
      checks++;
      if ({bus_if.lose, bus_if.win, bus_if.draw, bus_if.strat_req} !== 4'b1000) begin
         $display("FAIL lose_flags got %b want 1000", {bus_if.lose, bus_if.win, bus_if.draw,
                  bus_if.strat_req});
         errors++;
      end
   endtask

   task automatic test_restart_and_draw;
      restart();
      press(4'd2);
      release_btn();
      bus_if.newGame_L = 1'b0;
      tick();
      checks++;
      if ({bus_if.hSet, bus_if.cSet, bus_if.cMove, bus_if.illegal, bus_if.win, bus_if.lose,
           bus_if.draw, bus_if.strat_req} !== 27'd0) begin
         $display("FAIL midreq_restart got h=%b c=%b m=%0d req=%b want all 0", bus_if.hSet,
                  bus_if.cSet, bus_if.cMove, bus_if.strat_req);
         errors++;
      end
      bus_if.newGame_L = 1'b1;
      tick();
      checks++;
      if (bus_if.cSet !== 9'b000010000 || bus_if.cMove !== 4'd5) begin
         $display("FAIL replay_first got c=%b m=%0d want 000010000 5", bus_if.cSet, bus_if.cMove);
         errors++;
      end
      press(4'd2); release_btn(); give(4'd7);
      press(4'd6); release_btn(); give(4'd9);
      press(4'd1); release_btn(); give(4'd4);
      press(4'd3); release_btn(); give(4'd8);
      tick();
      checks++;
      if (bus_if.cSet !== 9'b111011000 || bus_if.hSet !== 9'b000100111 ||
          bus_if.cMove !== 4'd8) begin
         $display("FAIL draw_sets got c=%b h=%b m=%0d want 111011000 000100111 8", bus_if.cSet,
                  bus_if.hSet, bus_if.cMove);
         errors++;
      end
      checks++;
      if ({bus_if.draw, bus_if.win, bus_if.lose, bus_if.strat_req} !== 4'b1000) begin
         $display("FAIL draw_flags got %b want 1000", {bus_if.draw, bus_if.win, bus_if.lose,
                  bus_if.strat_req});
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_human_and_strat();
      test_illegal();
      test_timeout();
      test_win();
      test_lose();
      test_restart_and_draw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
